rj_seq_monitor: RTL and testbench
=================================

Name: rj_seq_monitor

Overview:
- Downstream checker for the 4-bit ring/Johnson counter.
- Samples the counter state `q` and mode select `rj` every clock.
- Decodes the state to a step index and flags illegal codes and illegal transitions.
- Tracks lock, counts completed sequence cycles and errors; outputs feed status/debug logic and the sequencer that consumes step numbers.

Parameters:
- CNT_W, 8, width of completed-cycle counter (wraps).
- ERR_W, 8, width of error counter (saturates).
- LOCK_N, 4, consecutive legal transitions needed to assert locked (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- q_in  input  4  counter state, one new value per clk.
- rj_in  input  1  mode: 1 = ring, 0 = Johnson.
- clr_stats  input  1  synchronous clear of err_cnt and cycle_cnt.
- step  output  3  decoded step index of last sample.
- step_valid  output  1  last sample was a legal in-sequence code.
- illegal_code  output  1  last sample not in current mode's code set.
- seq_err  output  1  one-cycle pulse: illegal code or wrong successor while locked.
- locked  output  1  LOCK_N consecutive legal transitions seen.
- wrap_pulse  output  1  one-cycle pulse on legal wrap transition.
- cycle_cnt  output  CNT_W  completed sequences, wraps at 2^CNT_W.
- err_cnt  output  ERR_W  seq_err events, saturates at all-ones.

Behaviour:
- Reset values (async, rst=1): all outputs 0; prev_q=0, prev_rj=0, have_prev=0, run count=0, FSM in UNLOCKED.
- Latency:
  - Every output is registered.
  - Values visible after edge N reflect q_in/rj_in sampled at edge N and compared with the sample from edge N-1.
- Decode, ring (rj=1):
  - 0001→0, 0010→1, 0100→2, 1000→3; step_valid=1.
  - 0000 is the start code: step=0, step_valid=0, illegal_code=0.
  - Any other code: illegal_code=1, step=0, step_valid=0.
- Decode, Johnson (rj=0):
  - 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7; step_valid=1.
  - The other 8 codes: illegal_code=1, step=0, step_valid=0.
- Legal successor:
  - Ring: 0000→0001, 0001→0010, 0010→0100, 0100→1000, 1000→0001 (wrap).
  - Johnson: step k→k+1 mod 8; 0001→0000 is the wrap.
  - A repeated code is illegal; the counter has no hold.
- FSM states: UNLOCKED, LOCKED.
  - UNLOCKED:
    - Each legal transition increments run count.
    - Any illegal code or transition resets run count to 0 with no seq_err.
    - When run count reaches LOCK_N, go to LOCKED; locked=1 from the edge of the LOCK_N-th legal transition.
  - LOCKED:
    - An illegal code or illegal transition → seq_err=1 for one cycle, err_cnt+1 (saturating), go to UNLOCKED, run count=0, locked=0 on that same edge.
- Mode change (rj_in ≠ prev_rj, have_prev=1):
  - Go to UNLOCKED, run count=0.
  - No seq_err, no wrap_pulse; the sample is still decoded under the new mode.
- First sample after reset (have_prev=0):
  - Decode only, no transition check.
  - have_prev is set.
- wrap_pulse:
  - Asserted for one cycle on a legal wrap transition, in either FSM state.
  - cycle_cnt increments on the same edge, wrapping from all-ones to 0.
- clr_stats=1:
  - err_cnt and cycle_cnt go to 0 on that edge; clear wins over a coincident increment.
  - seq_err and wrap_pulse are still reported; FSM is unaffected.
- Reset mid-operation: all state is lost immediately; the next sample is treated as first.

Test Plan:
1. Ring run: rst, then rj=1, q=0,1,2,4,8,1,2 → step 0,0,1,2,3,0,1; step_valid 0,1,1,1,1,1,1; locked=1 after the 4th transition (after the q=8 sample); wrap_pulse and cycle_cnt=1 on the 8→1 sample.
2. Johnson full loop: rj=0, q=0,8,12,14,15,7,3,1,0 → step 0..7,0; one wrap_pulse on 1→0; cycle_cnt=1; locked=1 from the q=15 sample.
3. Locked error: after lock in Johnson, inject q=5 → illegal_code=1, seq_err pulse, err_cnt=1, locked=0; resume the legal sequence → re-lock after 4 more legal transitions.
4. Mode switch: locked in ring at q=4, then rj=0 with q=8 → no seq_err, locked=0, step=1, step_valid=1; err_cnt unchanged.
5. Saturation/clear: ERR_W=2, force 5 locked errors → err_cnt sticks at 3; clr_stats coincident with a wrap → cycle_cnt=0 while wrap_pulse=1.
6. Async reset mid-run: assert rst between edges while locked → all outputs 0 immediately; the first post-reset sample produces no seq_err, even if it is not the successor of the pre-reset state.

Source files
------------

// File: rtl/rj_seq_monitor_if.sv
// rj_seq_monitor_if: counter sample inputs and status outputs of the sequence monitor
interface rj_seq_monitor_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
);
    logic [3:0]       q_in;
    logic             rj_in;
    logic             clr_stats;
    logic [2:0]       step;
    logic             step_valid;
    logic             illegal_code;
    logic             seq_err;
    logic             locked;
    logic             wrap_pulse;
    logic [CNT_W-1:0] cycle_cnt;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output q_in, rj_in, clr_stats,
        input  step, step_valid, illegal_code, seq_err, locked, wrap_pulse, cycle_cnt, err_cnt
    );

    modport slave (
        input  q_in, rj_in, clr_stats,
        output step, step_valid, illegal_code, seq_err, locked, wrap_pulse, cycle_cnt, err_cnt
    );
endinterface

// File: rtl/rj_seq_monitor.sv
// rj_seq_monitor: decodes ring/Johnson counter states and checks lock, wraps and sequence errors
module rj_seq_monitor #(
    parameter int CNT_W  = 8,
    parameter int ERR_W  = 8,
    parameter int LOCK_N = 4
) (
    input logic clk,
    input logic rst,
    rj_seq_monitor_if.slave bus
);
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       prev_code_q;
    logic             prev_rj_q;
    logic             have_prev_q;
    logic [2:0]       step_q, step_d;
    logic             step_valid_q, step_valid_d;
    logic             illegal_code_q, illegal_code_d;
    logic             seq_err_q, seq_err_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             p_ill, p_val, check, mode_chg, legal;
    logic [2:0]       p_step;
    logic [3:0]       ring_nxt;

    // Returns {illegal, valid, step}; ring start code 0000 is neither illegal nor valid
    function automatic logic [4:0] decode(input logic [3:0] c, input logic r);
        if (r) begin
            case (c)
                4'b0000: decode = 5'b00_000;
                4'b0001: decode = 5'b01_000;
                4'b0010: decode = 5'b01_001;
                4'b0100: decode = 5'b01_010;
                4'b1000: decode = 5'b01_011;
                default: decode = 5'b10_000;
            endcase
        end else begin
            case (c)
                4'b0000: decode = 5'b01_000;
                4'b1000: decode = 5'b01_001;
                4'b1100: decode = 5'b01_010;
                4'b1110: decode = 5'b01_011;
                4'b1111: decode = 5'b01_100;
                4'b0111: decode = 5'b01_101;
                4'b0011: decode = 5'b01_110;
                4'b0001: decode = 5'b01_111;
                default: decode = 5'b10_000;
            endcase
        end
    endfunction

    // Decode the sample, judge the transition from the previous sample and step the lock FSM
    always_comb begin
        {illegal_code_d, step_valid_d, step_d} = decode(bus.q_in, bus.rj_in);
        {p_ill, p_val, p_step} = decode(prev_code_q, bus.rj_in);
        check    = have_prev_q && (bus.rj_in == prev_rj_q);
        mode_chg = have_prev_q && (bus.rj_in != prev_rj_q);
        ring_nxt = (prev_code_q == 4'b0000 || prev_code_q == 4'b1000) ? 4'b0001 : {prev_code_q[2:0], 1'b0};
        legal    = bus.rj_in ? (!p_ill && bus.q_in == ring_nxt)
                             : (p_val && step_valid_d && step_d == p_step + 3'd1);
        wrap_d   = check && legal && (prev_code_q == (bus.rj_in ? 4'b1000 : 4'b0001));
        state_d   = state_q;
        run_d     = run_q;
        seq_err_d = 1'b0;
        if (mode_chg) begin
            state_d = UNLOCKED;
            run_d   = 4'd0;
        end else if (check) begin
            if (state_q == LOCKED) begin
                if (!legal) begin
                    seq_err_d = 1'b1;
                    state_d   = UNLOCKED;
                    run_d     = 4'd0;
                end
            end else if (legal) begin
                run_d = run_q + 4'd1;
                if (run_d == 4'(LOCK_N)) state_d = LOCKED;
            end else begin
                run_d = 4'd0;
            end
        end
        cycle_d = bus.clr_stats ? '0 : cycle_q + (wrap_d ? CNT_W'(1) : '0);
        err_d   = bus.clr_stats ? '0 : (seq_err_d && !(&err_q)) ? err_q + ERR_W'(1) : err_q;
    end

    // Register all state and outputs; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= UNLOCKED;
            run_q          <= '0;
            prev_code_q    <= '0;
            prev_rj_q      <= 1'b0;
            have_prev_q    <= 1'b0;
            step_q         <= '0;
            step_valid_q   <= 1'b0;
            illegal_code_q <= 1'b0;
            seq_err_q      <= 1'b0;
            wrap_q         <= 1'b0;
            cycle_q        <= '0;
            err_q          <= '0;
        end else begin
            state_q        <= state_d;
            run_q          <= run_d;
            prev_code_q    <= bus.q_in;
            prev_rj_q      <= bus.rj_in;
            have_prev_q    <= 1'b1;
            step_q         <= step_d;
            step_valid_q   <= step_valid_d;
            illegal_code_q <= illegal_code_d;
            seq_err_q      <= seq_err_d;
            wrap_q         <= wrap_d;
            cycle_q        <= cycle_d;
            err_q          <= err_d;
        end
    end

    assign bus.step         = step_q;
    assign bus.step_valid   = step_valid_q;
    assign bus.illegal_code = illegal_code_q;
    assign bus.seq_err      = seq_err_q;
    assign bus.locked       = (state_q == LOCKED);
    assign bus.wrap_pulse   = wrap_q;
    assign bus.cycle_cnt    = cycle_q;
    assign bus.err_cnt      = err_q;
endmodule

// File: tb/tb_rj_seq_monitor.sv
// tb_rj_seq_monitor: directed and random samples checked against a sequence-table model
module tb_rj_seq_monitor;
    localparam int CNT_W  = 3;
    localparam int ERR_W  = 2;
    localparam int LOCK_N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    rj_seq_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus();
    rj_seq_monitor #(.CNT_W(CNT_W), .ERR_W(ERR_W), .LOCK_N(LOCK_N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic [3:0] ring_seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] john_seq [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

    bit         m_have, m_prev_rj, m_locked;
    logic [3:0] m_prev;
    int         m_run, m_cyc, m_err;

    function automatic int find(input logic [3:0] c, input bit r);
        find = -1;
        if (r) begin
            for (int i = 0; i < 4; i++) if (ring_seq[i] == c) find = i;
        end else begin
            for (int i = 0; i < 8; i++) if (john_seq[i] == c) find = i;
        end
    endfunction

    function automatic logic [3:0] next_code(input logic [3:0] p, input bit r);
        int k;
        k = find(p, r);
        if (r) next_code = (k < 0) ? 4'b0001 : ring_seq[(k + 1) % 4];
        else   next_code = (k < 0) ? 4'b0000 : john_seq[(k + 1) % 8];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".step"},  8'(bus.step), 8'd0);
        chk({tag, ".valid"}, 8'(bus.step_valid), 8'd0);
        chk({tag, ".ill"},   8'(bus.illegal_code), 8'd0);
        chk({tag, ".serr"},  8'(bus.seq_err), 8'd0);
        chk({tag, ".lock"},  8'(bus.locked), 8'd0);
        chk({tag, ".wrap"},  8'(bus.wrap_pulse), 8'd0);
        chk({tag, ".cyc"},   8'(bus.cycle_cnt), 8'd0);
        chk({tag, ".err"},   8'(bus.err_cnt), 8'd0);
    endtask

    task automatic model_reset();
        m_have = 0; m_prev_rj = 0; m_locked = 0; m_prev = 4'd0;
        m_run = 0; m_cyc = 0; m_err = 0;
    endtask

    task automatic sample(input string tag, input logic [3:0] q, input bit r, input bit clr);
        int  idx, pidx, len;
        bit  legal, wrap, serr, ill, vld;
        @(negedge clk);
        bus.q_in = q; bus.rj_in = r; bus.clr_stats = clr;
        @(posedge clk);
        #1;
        idx  = find(q, r);
        len  = r ? 4 : 8;
        vld  = idx >= 0;
        ill  = !vld && !(r && q == 4'b0000);
        wrap = 0; serr = 0;
        if (m_have && r != m_prev_rj) begin
            m_locked = 0; m_run = 0;
        end else if (m_have) begin
            pidx  = find(m_prev, r);
            legal = (r && m_prev == 4'b0000 && q == 4'b0001) || (pidx >= 0 && idx == (pidx + 1) % len);
            wrap  = legal && pidx == len - 1;
            if (m_locked) begin
                if (!legal) begin
                    serr = 1; m_locked = 0; m_run = 0;
                    if (m_err < (1 << ERR_W) - 1) m_err++;
                end
            end else if (legal) begin
                m_run++;
                if (m_run == LOCK_N) m_locked = 1;
            end else begin
                m_run = 0;
            end
            if (wrap) m_cyc = (m_cyc + 1) % (1 << CNT_W);
        end
        if (clr) begin m_cyc = 0; m_err = 0; end
        m_have = 1; m_prev = q; m_prev_rj = r;
        chk({tag, ".step"},  8'(bus.step), vld ? 8'(idx) : 8'd0);
        chk({tag, ".valid"}, 8'(bus.step_valid), 8'(vld));
        chk({tag, ".ill"},   8'(bus.illegal_code), 8'(ill));
        chk({tag, ".serr"},  8'(bus.seq_err), 8'(serr));
        chk({tag, ".lock"},  8'(bus.locked), 8'(m_locked));
        chk({tag, ".wrap"},  8'(bus.wrap_pulse), 8'(wrap));
        chk({tag, ".cyc"},   8'(bus.cycle_cnt), 8'(m_cyc));
        chk({tag, ".err"},   8'(bus.err_cnt), 8'(m_err));
    endtask

    initial begin
        logic [3:0] q;
        bit r;
        bus.q_in = 4'd0; bus.rj_in = 1'b0; bus.clr_stats = 1'b0;
        model_reset();
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        foreach (ring_seq[i]) begin end
        sample("ring0", 4'b0000, 1, 0);
        sample("ring1", 4'b0001, 1, 0);
        sample("ring2", 4'b0010, 1, 0);
        sample("ring4", 4'b0100, 1, 0);
        sample("ring8", 4'b1000, 1, 0);
        chk("ring_locked", 8'(bus.locked), 8'd1);
        sample("ringw", 4'b0001, 1, 0);
        chk("ring_wrap", 8'(bus.wrap_pulse), 8'd1);
        sample("ring2b", 4'b0010, 1, 0);
        for (int i = 0; i < 8; i++) sample("john", john_seq[i], 0, 0);
        sample("john_wrap", 4'b0000, 0, 0);
        chk("john_wrap_pulse", 8'(bus.wrap_pulse), 8'd1);
        sample("lock_err", 4'b0101, 0, 0);
        chk("lock_err_serr", 8'(bus.seq_err), 8'd1);
        for (int i = 1; i < 6; i++) sample("relock", john_seq[i], 0, 0);
        chk("relocked", 8'(bus.locked), 8'd1);
        for (int i = 0; i < 4; i++) sample("ring_again", ring_seq[i], 1, 0);
        sample("ring_again", 4'b0001, 1, 0);
        sample("ring_again", 4'b0010, 1, 0);
        sample("ring_again", 4'b0100, 1, 0);
        sample("mode_sw", 4'b1000, 0, 0);
        chk("mode_sw_step", 8'(bus.step), 8'd1);
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 5; i++) sample("sat_run", john_seq[i], 0, 0);
            sample("sat_err", 4'b1010, 0, 0);
        end
        chk("err_sat", 8'(bus.err_cnt), 8'd3);
        for (int i = 0; i < 8; i++) sample("clr_run", john_seq[i], 0, 0);
        sample("clr_wrap", 4'b0000, 0, 1);
        chk("clr_wrap_pulse", 8'(bus.wrap_pulse), 8'd1);
        for (int i = 1; i < 6; i++) sample("pre_rst", john_seq[i], 0, 0);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        sample("post_rst", 4'b0100, 1, 0);
        sample("post_rst2", 4'b0001, 1, 0);
        r = 1'b1; q = 4'b0001;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 3) r = ~r;
            q = ($urandom_range(0, 99) < 88) ? next_code(q, r) : 4'($urandom_range(0, 15));
            sample("rand", q, r, $urandom_range(0, 99) < 4);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
